serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 148 ++++++++++++++
 tb/tb_serial_deserializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: packs WIDTH-bit beats MSB-first into a 32-bit word with a held output and overrun flag.
// Optional inactivity timeout is compiled in when RX_TIMEOUT_EN is defined.
module serial_deserializer #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             DinValid,
  input  logic             TxDone,
  input  logic             DataAck,
  output logic [31:0]      DataOut,
  output logic             DataValid,
  output logic             RxBusy,
  output logic             FrameError,
  output logic             Overrun
);

  localparam int BEATS = 32 / WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // Only the earlier beats are stored; the current beat joins them straight from Din.
  logic [31-WIDTH:0]      shreg_q, shreg_d;
  logic [31:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;

  logic [31:0]            word_w;
  logic                   complete;
  logic                   abort;
  logic                   timeout_hit;

  assign word_w = {shreg_q, Din};

`ifdef RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic             counting;

  always_comb begin
    counting    = (state_q == SHIFT) && !DinValid;
    gap_inc     = gap_q + GAP_W'(1);
    timeout_hit = counting && (gap_inc == GAP_W'(TIMEOUT));
    gap_d       = (counting && !timeout_hit) ? gap_inc : '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Datapath next-state: beat shift, completion, abort and output hand-off.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (DinValid) begin
      shreg_d = word_w[31-WIDTH:0];
      if (cnt_q == LAST_BEAT) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // TxDone is judged against the count after this cycle's beat.
    abort = (TxDone && (cnt_d != '0)) || timeout_hit;
    if (abort) begin
      cnt_d   = '0;
      shreg_d = '0;
    end
    fe_d = abort;

    if (complete) begin
      if (!valid_q || DataAck) begin
        data_d  = word_w;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (DataAck) begin
      valid_d = 1'b0;
    end
  end

  // FSM: state register.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (DinValid && (BEATS > 1) && !abort) state_d = SHIFT;
      SHIFT:   if (complete || abort)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    RxBusy = (state_q == SHIFT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign DataOut    = data_q;
  assign DataValid  = valid_q;
  assign FrameError = fe_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based word-assembly model.
module tb_serial_deserializer;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance under full model checking.
  logic [3:0]  din;
  logic        din_valid, tx_done, data_ack;
  logic [31:0] data_out;
  logic        data_valid, rx_busy, frame_error, overrun;

  // WIDTH=1 and WIDTH=16 instances for word-assembly checks.
  logic [0:0]  din1;
  logic        din_valid1;
  logic [31:0] data_out1;
  logic        data_valid1, rx_busy1, frame_error1, overrun1;
  logic [15:0] din16;
  logic        din_valid16;
  logic [31:0] data_out16;
  logic        data_valid16, rx_busy16, frame_error16, overrun16;

  serial_deserializer #(.WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
    .Clk(clk), .Reset(rst_n), .Din(din), .DinValid(din_valid), .TxDone(tx_done),
    .DataAck(data_ack), .DataOut(data_out), .DataValid(data_valid), .RxBusy(rx_busy),
    .FrameError(frame_error), .Overrun(overrun));

  serial_deserializer #(.WIDTH(1), .TIMEOUT(TIMEOUT)) dut_w1 (
    .Clk(clk), .Reset(rst_n), .Din(din1), .DinValid(din_valid1), .TxDone(1'b0),
    .DataAck(1'b0), .DataOut(data_out1), .DataValid(data_valid1), .RxBusy(rx_busy1),
    .FrameError(frame_error1), .Overrun(overrun1));

  serial_deserializer #(.WIDTH(16), .TIMEOUT(TIMEOUT)) dut_w16 (
    .Clk(clk), .Reset(rst_n), .Din(din16), .DinValid(din_valid16), .TxDone(1'b0),
    .DataAck(1'b0), .DataOut(data_out16), .DataValid(data_valid16), .RxBusy(rx_busy16),
    .FrameError(frame_error16), .Overrun(overrun16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: collected nibbles in a queue, word folded when eight have arrived.
  bit [3:0]  m_part[$];
  bit [31:0] m_out;
  bit        m_valid, m_ovr, m_fe;
  int        m_gap;

  task automatic model_reset();
    m_part.delete();
    m_out = '0; m_valid = 0; m_ovr = 0; m_fe = 0; m_gap = 0;
  endtask

  task automatic model_step(input bit v, input bit [3:0] d, input bit td, input bit ack);
    bit        done = 0;
    bit [31:0] w = '0;
    int        pre = m_part.size();
    m_fe = 0;
    if (!v && pre != 0) m_gap++;
    else                m_gap = 0;
    if (v) begin
      m_part.push_back(d);
      if (m_part.size() == 8) begin
        foreach (m_part[i]) w = {w[27:0], m_part[i]};
        m_part.delete();
        done = 1;
      end
    end
    if ((td && m_part.size() != 0)
`ifdef RX_TIMEOUT_EN
        || (m_gap == TIMEOUT)
`endif
       ) begin
      m_part.delete();
      m_fe  = 1;
      m_gap = 0;
    end
    if (done) begin
      if (!m_valid || ack) begin m_out = w; m_valid = 1; end
      else m_ovr = 1;
    end else if (ack) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".dout"},  data_out,             m_out);
    check({tag, ".dv"},    32'(data_valid),      32'(m_valid));
    check({tag, ".busy"},  32'(rx_busy),         32'(m_part.size() != 0));
    check({tag, ".fe"},    32'(frame_error),     32'(m_fe));
    check({tag, ".ovr"},   32'(overrun),         32'(m_ovr));
  endtask

  task automatic step(input string tag, input bit v, input bit [3:0] d, input bit td, input bit ack);
    din_valid = v; din = d; tx_done = td; data_ack = ack;
    @(posedge clk);
    model_step(v, d, td, ack);
    #1;
    compare_all(tag);
  endtask

  task automatic feed_word(input string tag, input bit [31:0] w, input bit ack_last);
    for (int i = 0; i < 8; i++) step(tag, 1'b1, w[31-4*i -: 4], 1'b0, ack_last && (i == 7));
  endtask

  task automatic idle_inputs();
    din = '0; din_valid = 0; tx_done = 0; data_ack = 0;
    din1 = '0; din_valid1 = 0; din16 = '0; din_valid16 = 0;
  endtask

  task automatic apply_reset(input string tag);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit [31:0] w;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full word then TxDone: normal end, no error.
    feed_word("deadbeef", 32'hDEADBEEF, 1'b0);
    check("deadbeef.direct", data_out, 32'hDEADBEEF);
    step("deadbeef.txdone", 1'b0, 4'h0, 1'b1, 1'b0);
    check("deadbeef.no_fe", 32'(frame_error), 32'd0);
    step("deadbeef.ack", 1'b0, 4'h0, 1'b0, 1'b1);

    // Short word aborted by TxDone, then a clean word.
    for (int i = 0; i < 3; i++) step("abort.beat", 1'b1, 4'(i + 1), 1'b0, 1'b0);
    step("abort.txdone", 1'b0, 4'h0, 1'b1, 1'b0);
    check("abort.fe_direct", 32'(frame_error), 32'd1);
    step("abort.fe_drop", 1'b0, 4'h0, 1'b0, 1'b0);
    feed_word("w12345678", 32'h12345678, 1'b0);
    check("w12345678.direct", data_out, 32'h12345678);
    step("w12345678.ack", 1'b0, 4'h0, 1'b0, 1'b1);

    // Two words without acknowledgement: second is dropped.
    feed_word("ovr.a5", 32'hA5A5A5A5, 1'b0);
    feed_word("ovr.5a", 32'h5A5A5A5A, 1'b0);
    check("ovr.keep_old", data_out, 32'hA5A5A5A5);
    check("ovr.flag", 32'(overrun), 32'd1);

    // Reset mid-word clears held word, overrun and partial beats.
    for (int i = 0; i < 5; i++) step("rst.beat", 1'b1, 4'hC, 1'b0, 1'b0);
    apply_reset("rst.mid");
    check("rst.dout_zero", data_out, 32'd0);
    feed_word("w0f0f", 32'h0F0F0F0F, 1'b0);
    check("w0f0f.direct", data_out, 32'h0F0F0F0F);
    step("w0f0f.ack", 1'b0, 4'h0, 1'b0, 1'b1);

    // Second word completing together with DataAck replaces the first.
    feed_word("ack.a5", 32'hA5A5A5A5, 1'b0);
    feed_word("ack.5a", 32'h5A5A5A5A, 1'b1);
    check("ack.new_word", data_out, 32'h5A5A5A5A);
    check("ack.no_ovr", 32'(overrun), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 3));

    // Narrow and wide instances assemble 0xCAFEF00D.
    apply_reset("rst.width");
    w = 32'hCAFEF00D;
    for (int i = 0; i < 32; i++) begin
      din_valid1  = 1'b1;
      din1        = w[31-i];
      din_valid16 = (i < 2);
      din16       = (i < 2) ? w[31-16*i -: 16] : 16'h0;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("w1.dout",   data_out1,  32'hCAFEF00D);
    check("w1.dv",     32'(data_valid1), 32'd1);
    check("w1.busy",   32'(rx_busy1),    32'd0);
    check("w16.dout",  data_out16, 32'hCAFEF00D);
    check("w16.dv",    32'(data_valid16), 32'd1);
    check("w16.ovr",   32'(overrun16),    32'd0);

    // Two beats then a long idle gap.
    apply_reset("rst.timeout");
    step("to.beat", 1'b1, 4'h3, 1'b0, 1'b0);
    step("to.beat", 1'b1, 4'h4, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) step("to.idle", 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef RX_TIMEOUT_EN
    check("to.fe_direct",   32'(frame_error), 32'd1);
    check("to.busy_direct", 32'(rx_busy),     32'd0);
`else
    check("to.busy_direct", 32'(rx_busy),     32'd1);
    check("to.no_fe",       32'(frame_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
